// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: debug-command driven control for a five-stage pipeline.
// Sequences IDLE/RUN/STEP/DRAIN/HALTED, resolves load-use stalls and taken
// branches into stage-register enables and bubble flushes, and counts the
// clocks in which the pipeline executes.
//
// Optional feature macro: PIPE_CYCLE_COUNT_EN
//   defined   -> o_cycle_count counts clocks spent in RUN/STEP/DRAIN
//   undefined -> no counter register, o_cycle_count tied to 0
//
// Ports:
//   clk, rst                     clock, synchronous active-low reset
//   i_cmd_run/step/halt          debug command pulses (halt > run > step)
//   i_halt_decoded               HALT opcode sitting in IF_ID
//   i_id_ex_MemRead, i_id_ex_rt  load in ID_EX and its destination
//   i_if_id_rs, i_if_id_rt       source operands of the instruction in ID
//   i_branch_taken               taken branch/jump resolved in EX
//   o_*_enable                   stage-register enables
//   o_if_id_flush, o_id_ex_flush bubble injection
//   o_state, o_done              encoded state, program halted
//   o_cycle_count                executed-clock counter
module pipeline_ctrl #(
   parameter int unsigned REG_ADDRS_BITS = 5,
   parameter int unsigned CNT_BITS       = 32
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      i_cmd_run,
   input  logic                      i_cmd_step,
   input  logic                      i_cmd_halt,
   input  logic                      i_halt_decoded,
   input  logic                      i_id_ex_MemRead,
   input  logic [REG_ADDRS_BITS-1:0] i_id_ex_rt,
   input  logic [REG_ADDRS_BITS-1:0] i_if_id_rs,
   input  logic [REG_ADDRS_BITS-1:0] i_if_id_rt,
   input  logic                      i_branch_taken,
   output logic                      o_pc_enable,
   output logic                      o_if_id_enable,
   output logic                      o_id_ex_enable,
   output logic                      o_ex_mem_enable,
   output logic                      o_mem_wb_enable,
   output logic                      o_if_id_flush,
   output logic                      o_id_ex_flush,
   output logic [2:0]                o_state,
   output logic                      o_done,
   output logic [CNT_BITS-1:0]       o_cycle_count
);

   localparam int unsigned DRAIN_LAST = 2;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      RUN    = 3'd1,
      STEP   = 3'd2,
      DRAIN  = 3'd3,
      HALTED = 3'd4
   } state_t;

   state_t     state, state_nxt;
   logic [1:0] drain_cnt, drain_cnt_nxt;
   logic       stall_c;

   // Load in EX whose destination feeds the instruction currently in ID
   assign stall_c = i_id_ex_MemRead &&
                    ((i_id_ex_rt == i_if_id_rs) || (i_id_ex_rt == i_if_id_rt));

   // State register
   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= IDLE;
         drain_cnt <= 2'd0;
      end else begin
         state     <= state_nxt;
         drain_cnt <= drain_cnt_nxt;
      end
   end

   // Next state and stage controls
   always_comb begin
      state_nxt       = state;
      drain_cnt_nxt   = drain_cnt;
      o_pc_enable     = 1'b0;
      o_if_id_enable  = 1'b0;
      o_id_ex_enable  = 1'b0;
      o_ex_mem_enable = 1'b0;
      o_mem_wb_enable = 1'b0;
      o_if_id_flush   = 1'b0;
      o_id_ex_flush   = 1'b0;
      o_done          = 1'b0;
      o_state         = 3'(state);

      case (state)
         IDLE: begin
            // A coincident halt suppresses run/step
            if (!i_cmd_halt) begin
               if (i_cmd_run)       state_nxt = RUN;
               else if (i_cmd_step) state_nxt = STEP;
            end
         end

         RUN, STEP: begin
            o_pc_enable     = 1'b1;
            o_if_id_enable  = 1'b1;
            o_id_ex_enable  = 1'b1;
            o_ex_mem_enable = 1'b1;
            o_mem_wb_enable = 1'b1;
            // Branch squashes the wrong-path instructions, so it wins over the stall
            if (i_branch_taken) begin
               o_if_id_flush = 1'b1;
               o_id_ex_flush = 1'b1;
            end else if (stall_c) begin
               o_pc_enable    = 1'b0;
               o_if_id_enable = 1'b0;
               o_id_ex_flush  = 1'b1;
            end

            if ((state == RUN) && i_cmd_halt) begin
               state_nxt = IDLE;
            end else if (i_halt_decoded && !i_branch_taken && !stall_c) begin
               state_nxt     = DRAIN;
               drain_cnt_nxt = 2'd0;
            end else if (state == STEP) begin
               state_nxt = IDLE;
            end
         end

         DRAIN: begin
            o_if_id_enable  = 1'b1;
            o_if_id_flush   = 1'b1;
            o_id_ex_enable  = 1'b1;
            o_id_ex_flush   = 1'b1;
            o_ex_mem_enable = 1'b1;
            o_mem_wb_enable = 1'b1;
            if (drain_cnt == 2'(DRAIN_LAST)) state_nxt = HALTED;
            else                             drain_cnt_nxt = drain_cnt + 2'd1;
         end

         HALTED: o_done = 1'b1;

         default: state_nxt = IDLE;
      endcase

      // Outputs read as reset state while rst is held, before the edge lands
      if (!rst) begin
         o_pc_enable     = 1'b0;
         o_if_id_enable  = 1'b0;
         o_id_ex_enable  = 1'b0;
         o_ex_mem_enable = 1'b0;
         o_mem_wb_enable = 1'b0;
         o_if_id_flush   = 1'b0;
         o_id_ex_flush   = 1'b0;
         o_done          = 1'b0;
         o_state         = 3'd0;
      end
   end

`ifdef PIPE_CYCLE_COUNT_EN
   logic [CNT_BITS-1:0] cycle_count;

   // Executed-clock counter, wraps naturally
   always_ff @(posedge clk) begin
      if (!rst)                                  cycle_count <= '0;
      else if (state inside {RUN, STEP, DRAIN})  cycle_count <= cycle_count + CNT_BITS'(1);
   end

   assign o_cycle_count = cycle_count;
`else
   assign o_cycle_count = '0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: directed vectors, a mode-level reference model
// compared every cycle, and literal expectations pinning the model.
module tb_pipeline_ctrl;
   localparam int unsigned RB = 5;
   localparam int unsigned CB = 32;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst, cmd_run, cmd_step, cmd_halt, halt_dec, mr, br;
   logic [RB-1:0] ex_rt, id_rs, id_rt;
   logic          pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_fl, idex_fl, done;
   logic [2:0]    st;
   logic [CB-1:0] cnt;

   pipeline_ctrl #(.REG_ADDRS_BITS(RB), .CNT_BITS(CB)) dut (
      .clk(clk), .rst(rst),
      .i_cmd_run(cmd_run), .i_cmd_step(cmd_step), .i_cmd_halt(cmd_halt),
      .i_halt_decoded(halt_dec), .i_id_ex_MemRead(mr),
      .i_id_ex_rt(ex_rt), .i_if_id_rs(id_rs), .i_if_id_rt(id_rt),
      .i_branch_taken(br),
      .o_pc_enable(pc_en), .o_if_id_enable(ifid_en), .o_id_ex_enable(idex_en),
      .o_ex_mem_enable(exmem_en), .o_mem_wb_enable(memwb_en),
      .o_if_id_flush(ifid_fl), .o_id_ex_flush(idex_fl),
      .o_state(st), .o_done(done), .o_cycle_count(cnt)
   );

   int n_checks = 0;
   int n_errors = 0;

   // Model: mode 0 idle, 1 run, 2 step, 3 drain, 4 halted
   int            m_mode = 0;
   int            m_left = 0;
   logic [CB-1:0] m_count = '0;
   int            pc_hi = 0;
   bit            count_pc = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit load_use();
      return mr && (ex_rt == id_rs || ex_rt == id_rt);
   endfunction

   // {pc, if_id, id_ex, ex_mem, mem_wb, if_id_flush, id_ex_flush, done}
   function automatic logic [7:0] model_out();
      if (!rst) return 8'h00;
      case (m_mode)
         1, 2: begin
            if (br)             return 8'b11111110;
            else if (load_use()) return 8'b00111010;
            else                return 8'b11111000;
         end
         3:       return 8'b01111110;
         4:       return 8'b00000001;
         default: return 8'h00;
      endcase
   endfunction

   function automatic logic [CB-1:0] exp_count();
`ifdef PIPE_CYCLE_COUNT_EN
      return m_count;
`else
      return '0;
`endif
   endfunction

   task automatic chk();
      #3;
      check("outputs", 32'({pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_fl, idex_fl, done}),
            32'(model_out()));
      check("state", 32'(st), rst ? 32'(m_mode) : 32'd0);
      if (rst) check("cycle_count", 32'(cnt), 32'(exp_count()));
      if (count_pc && pc_en) pc_hi++;
   endtask

   task automatic tick();
      int            nm = m_mode;
      int            nl = m_left;
      logic [CB-1:0] nc = m_count;
      if (!rst) begin
         nm = 0; nl = 0; nc = '0;
      end else begin
         case (m_mode)
            0: if (!cmd_halt) begin
                  if (cmd_run)       nm = 1;
                  else if (cmd_step) nm = 2;
               end
            1, 2: begin
               nc = nc + 1;
               if (m_mode == 1 && cmd_halt)                nm = 0;
               else if (halt_dec && !br && !load_use()) begin nm = 3; nl = 3; end
               else if (m_mode == 2)                       nm = 0;
            end
            3: begin
               nc = nc + 1;
               nl = nl - 1;
               if (nl == 0) nm = 4;
            end
            default: ;
         endcase
      end
      @(posedge clk);
      m_mode = nm; m_left = nl; m_count = nc;
      #1;
      cmd_run = 0; cmd_step = 0; cmd_halt = 0; halt_dec = 0; br = 0; mr = 0;
   endtask

   task automatic cyc();
      chk();
      tick();
   endtask

   initial begin
      rst = 0; cmd_run = 0; cmd_step = 0; cmd_halt = 0; halt_dec = 0; mr = 0; br = 0;
      ex_rt = '0; id_rs = '0; id_rt = '0;
      tick(); tick();
      chk();
      check("reset_state_lit", 32'(st), 32'd0);
      check("reset_pc_lit", 32'(pc_en), 32'd0);
      tick();
      rst = 1;
      cyc();

      // Three single steps separated by two idle clocks
      count_pc = 1'b1;
      repeat (3) begin
         cmd_step = 1; cyc(); cyc(); cyc();
      end
      count_pc = 1'b0;
      chk();
      check("step_pc_pulses_lit", 32'(pc_hi), 32'd3);
      check("step_state_lit", 32'(st), 32'd0);
`ifdef PIPE_CYCLE_COUNT_EN
      check("step_count_lit", 32'(cnt), 32'd3);
`else
      check("step_count_lit", 32'(cnt), 32'd0);
`endif
      tick();

      // A stalled step still consumes the step
      cmd_step = 1; cyc();
      mr = 1; ex_rt = 5; id_rs = 5; id_rt = 0;
      chk();
      check("step_stall_pc_lit", 32'(pc_en), 32'd0);
      tick();
      chk();
      check("step_consumed_lit", 32'(st), 32'd0);
      tick();

      // run beats step
      cmd_run = 1; cmd_step = 1; cyc();
      chk();
      check("prio_run_lit", 32'(st), 32'd1);
      tick();

      // Load-use on rs, no match, match on rt
      mr = 1; ex_rt = 5; id_rs = 5; id_rt = 0;
      chk();
      check("lu_pc_lit", 32'(pc_en), 32'd0);
      check("lu_ifid_lit", 32'(ifid_en), 32'd0);
      check("lu_flush_lit", 32'(idex_fl), 32'd1);
      check("lu_exmem_lit", 32'(exmem_en), 32'd1);
      tick();
      mr = 1; ex_rt = 6; id_rs = 5; id_rt = 7;
      chk();
      check("nolu_pc_lit", 32'(pc_en), 32'd1);
      check("nolu_flush_lit", 32'(idex_fl), 32'd0);
      tick();
      mr = 1; ex_rt = 7; id_rs = 1; id_rt = 7; cyc();

      // Branch over stall with wrong-path halt
      br = 1; mr = 1; ex_rt = 5; id_rs = 5; halt_dec = 1;
      chk();
      check("br_pc_lit", 32'(pc_en), 32'd1);
      check("br_ifid_fl_lit", 32'(ifid_fl), 32'd1);
      check("br_idex_fl_lit", 32'(idex_fl), 32'd1);
      tick();
      chk();
      check("br_halt_ignored_lit", 32'(st), 32'd1);
      tick();

      // Halt deferred by a stall, then pause and resume
      halt_dec = 1; mr = 1; ex_rt = 3; id_rs = 3; cyc();
      chk();
      check("halt_deferred_lit", 32'(st), 32'd1);
      tick();
      cmd_halt = 1; cyc();
      chk();
      check("pause_lit", 32'(st), 32'd0);
      tick();
      cmd_run = 1; cyc();

      // Halt decode -> three drain clocks -> halted
      halt_dec = 1; cyc();
      for (int i = 0; i < 3; i++) begin
         if (i == 1) cmd_run = 1;
         chk();
         check("drain_state_lit", 32'(st), 32'd3);
         check("drain_pc_lit", 32'(pc_en), 32'd0);
         tick();
      end
      chk();
      check("halted_state_lit", 32'(st), 32'd4);
      check("halted_done_lit", 32'(done), 32'd1);
      tick();
      cmd_run = 1; cyc();
      cmd_step = 1; cyc();
      cmd_halt = 1; cyc();
      chk();
      check("halted_sticky_lit", 32'(st), 32'd4);
      tick();

      // Reset in the middle of a drain
      rst = 0; cyc();
      rst = 1; cmd_run = 1; cyc();
      halt_dec = 1; cyc();
      cyc();
      rst = 0;
      chk();
      check("rst_gate_state_lit", 32'(st), 32'd0);
      check("rst_gate_pc_lit", 32'(pc_en), 32'd0);
      tick();
      rst = 1;
      chk();
      check("rst_drain_state_lit", 32'(st), 32'd0);
      check("rst_drain_count_lit", 32'(cnt), 32'd0);
      check("rst_drain_en_lit", 32'({pc_en, ifid_en, idex_en, exmem_en, memwb_en}), 32'd0);
      tick();
      cyc(); cyc();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
